// File: rtl/hart_bewaking.sv
// Heart-rhythm monitor: 4-window moving average of beat counts, hysteretic
// LOW/NORMAL/HIGH classification and a sustained-abnormality alarm.
module hart_bewaking #(
    parameter logic [7:0]  LOW_THR   = 8'd50,
    parameter logic [7:0]  HIGH_THR  = 8'd120,
    parameter logic [7:0]  HYST      = 8'd5,
    parameter int unsigned ALARM_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slag_valid,
    input  logic [7:0] slagen,
    output logic [7:0] gem,
    output logic       gem_valid,
    output logic [1:0] toestand,
    output logic       upd,
    output logic       alarm
);

    localparam logic [1:0] ST_WARMUP  = 2'd0;
    localparam logic [1:0] ST_NORMAAL = 2'd1;
    localparam logic [1:0] ST_LAAG    = 2'd2;
    localparam logic [1:0] ST_HOOG    = 2'd3;

    // 9-bit thresholds so the hysteresis offsets cannot wrap
    localparam logic [8:0] LOW9       = {1'b0, LOW_THR};
    localparam logic [8:0] HIGH9      = {1'b0, HIGH_THR};
    localparam logic [8:0] LOW_HYST9  = LOW9 + {1'b0, HYST};
    localparam logic [8:0] HIGH_HYST9 = HIGH9 - {1'b0, HYST};
    localparam logic [3:0] ALARM_MAX  = 4'(ALARM_CNT);

    logic [7:0] r_buf [4];
    logic [1:0] r_ptr;
    logic [9:0] r_sum;
    logic [2:0] r_fill;
    logic [7:0] r_gem;
    logic       r_gem_valid;
    logic       r_eval;
    logic       r_upd;
    logic [1:0] r_state;
    logic [3:0] r_abn;
    logic       r_alarm;

    logic [9:0] w_sum_new;
    logic [7:0] w_avg;
    logic [2:0] w_fill_new;
    logic       w_full_new;
    logic [8:0] w_gem9;
    logic [1:0] w_state_next;
    logic [3:0] w_abn_next;

    assign w_sum_new  = r_sum - {2'b00, r_buf[r_ptr]} + {2'b00, slagen};
    assign w_avg      = 8'(w_sum_new >> 2);
    assign w_fill_new = (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
    assign w_full_new = (w_fill_new == 3'd4);
    assign w_gem9     = {1'b0, r_gem};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WARMUP: begin
                if (w_gem9 < LOW9)       w_state_next = ST_LAAG;
                else if (w_gem9 > HIGH9) w_state_next = ST_HOOG;
                else                     w_state_next = ST_NORMAAL;
            end
            ST_NORMAAL: begin
                if (w_gem9 < LOW9)       w_state_next = ST_LAAG;
                else if (w_gem9 > HIGH9) w_state_next = ST_HOOG;
            end
            ST_LAAG: begin
                if (w_gem9 > HIGH9)           w_state_next = ST_HOOG;
                else if (w_gem9 >= LOW_HYST9) w_state_next = ST_NORMAAL;
            end
            default: begin
                if (w_gem9 < LOW9)             w_state_next = ST_LAAG;
                else if (w_gem9 <= HIGH_HYST9) w_state_next = ST_NORMAAL;
            end
        endcase
    end

    // A direct LOW<->HIGH swing restarts the abnormal run at one
    always_comb begin
        w_abn_next = r_abn;
        if (w_state_next == ST_NORMAAL || w_state_next == ST_WARMUP)
            w_abn_next = 4'd0;
        else if ((r_state == ST_LAAG && w_state_next == ST_HOOG) ||
                 (r_state == ST_HOOG && w_state_next == ST_LAAG))
            w_abn_next = 4'd1;
        else if (r_abn >= ALARM_MAX)
            w_abn_next = ALARM_MAX;
        else
            w_abn_next = r_abn + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= 8'd0;
        end else if (slag_valid) begin
            r_buf[r_ptr] <= slagen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= 2'd0;
            r_sum       <= 10'd0;
            r_fill      <= 3'd0;
            r_gem       <= 8'd0;
            r_gem_valid <= 1'b0;
            r_eval      <= 1'b0;
            r_upd       <= 1'b0;
            r_state     <= ST_WARMUP;
            r_abn       <= 4'd0;
            r_alarm     <= 1'b0;
        end else begin
            r_upd  <= r_eval;
            r_eval <= slag_valid & w_full_new;
            if (slag_valid) begin
                r_sum       <= w_sum_new;
                r_ptr       <= r_ptr + 2'd1;
                r_fill      <= w_fill_new;
                // Average is withheld until four real samples are present
                r_gem       <= w_full_new ? w_avg : 8'd0;
                r_gem_valid <= w_full_new;
            end
            if (r_eval) begin
                r_state <= w_state_next;
                r_abn   <= w_abn_next;
                r_alarm <= (w_abn_next == ALARM_MAX);
            end
        end
    end

    assign gem       = r_gem;
    assign gem_valid = r_gem_valid;
    assign toestand  = r_state;
    assign upd       = r_upd;
    assign alarm     = r_alarm;

endmodule

// File: tb/tb_hart_bewaking.sv
// Bench for hart_bewaking: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hart_bewaking;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slag_valid = 1'b0;
    logic [7:0] slagen = 8'd0;
    logic [7:0] gem;
    logic       gem_valid;
    logic [1:0] toestand;
    logic       upd;
    logic       alarm;

    hart_bewaking dut (
        .clk       (clk),
        .reset     (reset),
        .slag_valid(slag_valid),
        .slagen    (slagen),
        .gem       (gem),
        .gem_valid (gem_valid),
        .toestand  (toestand),
        .upd       (upd),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: history of real samples, expected outputs
    int m_hist[$];
    int m_gem, m_valid, m_state, m_upd, m_alarm, m_abn, m_pending;
    int last_gem, last_upd, upd_seen;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_gem = 0; m_valid = 0; m_state = 0; m_upd = 0;
        m_alarm = 0; m_abn = 0; m_pending = 0;
    endtask

    function automatic int classify(input int st, input int g);
        int ns = st;
        if (st == 0)      ns = (g < 50) ? 2 : (g > 120) ? 3 : 1;
        else if (st == 1) ns = (g < 50) ? 2 : (g > 120) ? 3 : 1;
        else if (st == 2) ns = (g > 120) ? 3 : (g >= 55) ? 1 : 2;
        else              ns = (g < 50) ? 2 : (g <= 115) ? 1 : 3;
        return ns;
    endfunction

    task automatic model_edge(input bit v, input int d, input bit r);
        int ns, s;
        if (r) begin
            model_reset();
            return;
        end
        m_upd = m_pending;
        if (m_pending) begin
            ns = classify(m_state, m_gem);
            if (ns == 1) m_abn = 0;
            else if (ns != m_state && m_state >= 2) m_abn = 1;
            else m_abn = (m_abn + 1 > 3) ? 3 : m_abn + 1;
            m_state = ns;
            m_alarm = (m_abn == 3);
        end
        m_pending = 0;
        if (v) begin
            m_hist.push_back(d);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
            if (m_hist.size() == 4) begin
                s = 0;
                foreach (m_hist[k]) s += m_hist[k];
                m_gem = s / 4;
                m_valid = 1;
                m_pending = 1;
            end else begin
                m_gem = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("gem", int'(gem), m_gem);
        chk("gem_valid", int'(gem_valid), m_valid);
        chk("toestand", int'(toestand), m_state);
        chk("upd", int'(upd), m_upd);
        chk("alarm", int'(alarm), m_alarm);
    endtask

    task automatic step(input bit v, input int d, input bit r);
        slag_valid = v;
        slagen     = 8'(d);
        reset      = r;
        @(posedge clk);
        model_edge(v, d, r);
        #1;
        compare_all();
        if (upd) upd_seen++;
        if (v) $display("[TB] strobe d=%0d rst=%0b -> gem=%0d valid=%0b state=%0d alarm=%0b",
                        d, r, gem, gem_valid, toestand, alarm);
    endtask

    // Strobe followed by two idle cycles; captures gem and the upd pulse
    task automatic strobe(input int d);
        step(1'b1, d, 1'b0);
        last_gem = int'(gem);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        last_upd = upd_seen;
    endtask

    int exp_warm[4] = '{0, 0, 0, 70};
    int exp_g40[3]  = '{62, 55, 47};
    int exp_s40[3]  = '{1, 1, 2};

    initial begin
        model_reset();
        upd_seen = 0;
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("reset_gem", int'(gem), 0);
        chk("reset_state", int'(toestand), 0);

        // Warm-up with 70s
        for (int i = 0; i < 4; i++) begin
            upd_seen = 0;
            strobe(70);
            chk("warm_gem", last_gem, exp_warm[i]);
        end
        chk("warm_valid", int'(gem_valid), 1);
        chk("warm_upd", last_upd, 1);
        chk("warm_state", int'(toestand), 1);

        // Drift low, then sustained LAAG raises alarm
        for (int i = 0; i < 3; i++) begin
            strobe(40);
            chk("g40_gem", last_gem, exp_g40[i]);
            chk("g40_state", int'(toestand), exp_s40[i]);
        end
        strobe(40);
        chk("laag_alarm2", int'(alarm), 0);
        strobe(40);
        chk("laag_alarm3", int'(alarm), 1);

        // Hysteresis on the way back up
        strobe(88);
        chk("hyst52_gem", last_gem, 52);
        chk("hyst52_state", int'(toestand), 2);
        strobe(52);
        chk("hyst55_gem", last_gem, 55);
        chk("hyst55_state", int'(toestand), 1);
        chk("hyst55_alarm", int'(alarm), 0);

        // HOOG then drop to 97
        for (int i = 0; i < 4; i++) strobe(130);
        chk("hoog_gem", last_gem, 130);
        chk("hoog_state", int'(toestand), 3);
        strobe(0);
        chk("drop_gem", last_gem, 97);
        chk("drop_state", int'(toestand), 1);
        chk("drop_alarm", int'(alarm), 0);

        // Back-to-back 255s
        upd_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 255, 1'b0);
        chk("b2b_gem", int'(gem), 255);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("b2b_upds", upd_seen, 4);
        chk("b2b_state", int'(toestand), 3);
        strobe(255);
        strobe(255);
        chk("b2b_alarm", int'(alarm), 1);

        // Reset with a concurrent strobe
        step(1'b1, 200, 1'b1);
        chk("rst_gem", int'(gem), 0);
        chk("rst_valid", int'(gem_valid), 0);
        chk("rst_state", int'(toestand), 0);
        chk("rst_alarm", int'(alarm), 0);
        for (int i = 0; i < 3; i++) strobe(200);
        chk("rst_still_warm", int'(gem_valid), 0);
        strobe(200);
        chk("rst_refill_valid", int'(gem_valid), 1);
        chk("rst_refill_gem", last_gem, 200);

        // Randomized traffic around the thresholds
        for (int i = 0; i < 600; i++) begin
            int d;
            bit v, r;
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 255);
                1: d = $urandom_range(40, 60);
                2: d = $urandom_range(110, 135);
                default: d = $urandom_range(0, 30);
            endcase
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 149) == 0);
            step(v, d, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hart_bewaking.md
HART_BEWAKING -- requirements
Module: hart_bewaking

Interface
REQ-001 Parameters SHALL be, one per line, as follows.
  LOW_THR, 8'd50, lower bound of the normal range, in beats per window.
  HIGH_THR, 8'd120, upper bound of the normal range, in beats per window.
  HYST, 8'd5, hysteresis margin applied when returning to NORMAL.
  ALARM_CNT, 3, consecutive abnormal classifications needed to raise alarm (range 1..15).
REQ-002 Ports SHALL be, one per line, as follows.
  clk  in  1  single system clock; all logic on its rising edge.
  reset  in  1  synchronous, active-high reset.
  slag_valid  in  1  one-cycle strobe; a new per-window beat count is present.
  slagen  in  8  beat count of the just-closed window (upstream beat counter output).
  gem  out  8  moving average of the last 4 window counts.
  gem_valid  out  1  gem holds an average over 4 real samples.
  toestand  out  2  rhythm class: 0 WARMUP, 1 NORMAAL, 2 LAAG, 3 HOOG.
  upd  out  1  one-cycle pulse; toestand/alarm were just re-evaluated.
  alarm  out  1  sustained abnormal rhythm.
REQ-003 The block SHALL use one clock and a synchronous active-high reset named reset; there SHALL be no other clock or asynchronous input.

Function
REQ-004 The block SHALL hold a 4-entry circular sample buffer, a 2-bit write pointer, a 10-bit running sum and a 3-bit fill count saturating at 4.
REQ-005 On a clk edge with slag_valid=1, the block SHALL:
  - compute sum_new = sum - buf[ptr] + slagen;
  - write slagen into buf[ptr];
  - increment ptr mod 4 and the fill count.
REQ-006 On that same edge, gem SHALL register sum_new[9:2] (truncating divide by 4), visible one cycle after the strobe.
REQ-007 gem_valid SHALL rise on the edge that takes the 4th sample after reset and stay high until reset; empty buffer slots SHALL read as 0 during warm-up.
REQ-008 upd SHALL pulse high exactly one cycle, two cycles after each strobe taken while gem_valid is high or becomes high; toestand and alarm SHALL change only on the edge that raises upd.
REQ-009 Classification from WARMUP on the first update SHALL be LAAG if gem<LOW_THR, HOOG if gem>HIGH_THR, else NORMAAL.
REQ-010 Transitions on each subsequent update, with all other cases holding state:
  - NORMAAL->LAAG if gem<LOW_THR.
  - NORMAAL->HOOG if gem>HIGH_THR.
  - LAAG->NORMAAL if gem>=LOW_THR+HYST.
  - HOOG->NORMAAL if gem<=HIGH_THR-HYST.
  - LAAG->HOOG if gem>HIGH_THR.
  - HOOG->LAAG if gem<LOW_THR.
REQ-011 Threshold arithmetic SHALL be 9-bit unsigned, so LOW_THR+HYST and HIGH_THR-HYST never wrap.
REQ-012 A 4-bit abnormal counter SHALL update on each upd edge:
  - set to 0 when the new state is NORMAAL;
  - set to 1 on a LAAG<->HOOG change;
  - otherwise increment when the new state is LAAG/HOOG, saturating at ALARM_CNT.
REQ-013 alarm SHALL be high exactly when the abnormal counter equals ALARM_CNT.
REQ-014 Strobes on consecutive cycles SHALL all be accepted with no loss; each strobe SHALL produce its own upd pulse in order.
REQ-015 The running sum SHALL never overflow: 4x255=1020 fits 10 bits.
REQ-016 slag_valid asserted in the same cycle as reset SHALL be ignored.

Reset
REQ-017 While reset is high at a clk edge, the block SHALL clear the following to 0: buffer, ptr, fill count, sum, gem, gem_valid, upd, abnormal counter, alarm.
REQ-018 Under reset, toestand SHALL go to WARMUP.
REQ-019 A reset mid-operation SHALL discard all history; warm-up SHALL restart, needing 4 new strobes before gem_valid.

Verification
REQ-020 Four strobes of 70 -> gem=0,0,0,70 after each strobe (70 one cycle after the 4th); gem_valid rises on the 4th; toestand NORMAAL, upd pulse two cycles after the 4th.
REQ-021 After the REQ-020 state, three strobes of 40 -> gem 62,55,47; toestand NORMAAL, NORMAAL, LAAG; then strobes of 40 -> alarm high after the 3rd consecutive LAAG update.
REQ-022 From LAAG with gem=47, strobes raising gem to 52 -> toestand stays LAAG; reaching 55 -> NORMAAL, abnormal counter 0, alarm low.
REQ-023 From a filled buffer of 130s (HOOG), one strobe of 0 -> gem 97; toestand NORMAAL (97<=115), alarm cleared.
REQ-024 Back-to-back strobes of 255 on four consecutive cycles -> gem=255, no overflow; four upd pulses on consecutive cycles; final toestand HOOG.
REQ-025 Reset asserted for one cycle after alarm is high -> every output 0 and toestand WARMUP next cycle; a strobe concurrent with reset is not counted.
